chien_search: RTL and testbench
===============================

// Module: chien_search
// PURPOSE
//  Downstream neighbour of the Berlekamp-Massey stage. Captures Lambda0..Lambda8 on the one-cycle BM_done pulse and
//  evaluates Lambda(x) at every codeword position, one position per clock, in received-symbol order (pos n-1 down to 0).
//  Flags error locations and exports the odd-term sum Lambda_odd for the Forney stage. Reports the root count and a
//  decode-failure flag.
// PARAMETERS
//  n  255  codeword length (symbols)
//  k  239  message length (informational; unused in logic)
//  t  8    max correctable symbols; Lambda has t+1 coefficients
//  m  8    symbol width; GF(2^8), primitive poly 0x11D
// PORTS
//  clk_in       in   1   clock
//  rst_in       in   1   synchronous, active-high reset
//  BM_done      in   1   one-cycle pulse; Lambda0..8 valid only in this cycle
//  Lambda0..8   in   m   error-locator coefficients (9 ports)
//  loc_valid    out  1   loc_pos/loc_flag/Lambda_odd valid this cycle
//  loc_pos      out  m   position index, n-1 first, 0 last
//  loc_flag     out  1   1 = Lambda(alpha^-loc_pos) == 0 (error at loc_pos)
//  Lambda_odd   out  m   XOR of odd-index terms at this position (= x*Lambda'(x))
//  search_done  out  1   one-cycle pulse after the last loc_valid
//  root_cnt     out  4   roots found; held from search_done until next start
//  decode_fail  out  1   held with root_cnt; 1 = root_cnt != deg(Lambda) or Lambda0 == 0
//  busy         out  1   1 while in SEARCH
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; internal registers 0. Reset overrides all else, including mid-search.
//  - States: IDLE, SEARCH. Any edge with BM_done=1 -> SEARCH. This holds from IDLE and from SEARCH (abort + restart).
//  - Capture edge:
//    - lam_reg[j] <= Lambda_j * alpha^j for j=0..8.
//    - pos <= n-1; roots <= 0; root_cnt, decode_fail cleared.
//    - deg <= highest j with Lambda_j != 0; deg = 0 if all are zero.
//    - lam0_zero <= (Lambda0 == 0).
//  - Each SEARCH edge:
//    - sum = XOR lam_reg[0..8].
//    - Registered outputs: loc_valid <= 1, loc_pos <= pos, loc_flag <= (sum == 0), Lambda_odd <= XOR lam_reg[odd j].
//    - lam_reg[j] <= lam_reg[j] * alpha^j, via constant multipliers.
//    - roots += (sum == 0); pos <= pos-1.
//  - Cycle c of SEARCH evaluates Lambda(alpha^(c+1)) = Lambda(alpha^-(n-1-c)), so loc_pos = n-1-c.
//  - Latency: BM_done high in cycle K -> first loc_valid in cycle K+2. Exactly n consecutive valid cycles follow.
//  - After the edge evaluating pos 0: state -> IDLE.
//  - Next cycle: loc_valid = 0; search_done = 1 for one cycle; root_cnt and decode_fail hold the final values.
//  - roots saturates at 15; deg <= 8, so saturation implies failure.
//  - BM_done coincident with the last SEARCH edge: restart wins; no search_done pulse for the aborted frame.
//  - All-zero Lambda: every position flags, and decode_fail = 1 because lam0_zero is set.
// STRUCTURE
//  - Shared package rs_pkg:
//    - N, T, M, PRIM_POLY = 9'h11D.
//    - localparam table ALPHA_POW[0..8] = 01,02,04,08,10,20,40,80,1D.
//  - Sub-module gf_const_mul (#(CONST)): combinational constant multiplier.
//    - 9 instances for the per-cycle step.
//    - The capture scaling reuses the existing GF_mul (9 instances).
//  - One FSM always block, one datapath always block, combinational XOR trees for sum and Lambda_odd.
// TESTING
//  1. No error:
//     - Stimulus: Lambda0=01, others 00, BM_done pulse.
//     - Response: 255 loc_valid cycles, pos FE..00, loc_flag never set; root_cnt=0, decode_fail=0 at search_done.
//  2. Single error at pos 254:
//     - Stimulus: Lambda0=01, Lambda1=8E (alpha^254).
//     - Response: loc_flag=1 only on the first valid cycle (pos FE); root_cnt=1, decode_fail=0.
//  3. Single error at pos 0:
//     - Stimulus: Lambda0=01, Lambda1=01.
//     - Response: loc_flag=1 only on the last valid cycle (pos 00); search_done on the next cycle.
//  4. Two errors at pos 10 and 200:
//     - Stimulus: Lambda = (1+alpha^10 x)(1+alpha^200 x), scaled by gamma=alpha^5.
//     - Response: flags at pos 0A and C8 only; root_cnt=2, decode_fail=0; Lambda_odd compared against a reference model.
//  5. Failure:
//     - Stimulus: degree-3 Lambda with only 1 root in the field.
//     - Response: root_cnt=1, decode_fail=1.
//  6. Disruptions:
//     - Stimulus: BM_done re-pulsed at valid cycle 100.
//     - Response: loc_pos restarts at FE two cycles later.
//     - Stimulus: rst_in=1 mid-search.
//     - Response: all outputs 0 next cycle; busy=0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: field size, code geometry and the GF(2^8) multiply
// used by the constant and general multipliers.
package rs_pkg;

   localparam int N = 255;
   localparam int K = 239;
   localparam int T = 8;
   localparam int M = 8;
   localparam logic [8:0] PRIM_POLY = 9'h11D;

   localparam logic [7:0] ALPHA_POW [0:8] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D
   };

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SEARCH = 1'b1
   } state_t;

   // Shift-and-add product reduced by the primitive polynomial
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      logic [M-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[M-2:0], 1'b0} ^ (aa[M-1] ? PRIM_POLY[M-1:0] : '0);
      end
      return p;
   endfunction

endpackage

// File: rtl/GF_mul.sv
// General combinational GF(2^8) multiplier.
module GF_mul
   import rs_pkg::*;
(
   input  logic [M-1:0] i_a,
   input  logic [M-1:0] i_b,
   output logic [M-1:0] o_p
);

   assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/gf_const_mul.sv
// Combinational GF(2^8) multiply by a compile-time constant.
module gf_const_mul
   import rs_pkg::*;
#(
   parameter logic [M-1:0] CONST = 8'h01
) (
   input  logic [M-1:0] i_a,
   output logic [M-1:0] o_p
);

   assign o_p = gf_mul(i_a, CONST);

endmodule

// File: rtl/chien_search.sv
// Chien search: evaluates the captured error locator at every codeword position, one per
// clock from n-1 down to 0, flags roots and exports the odd-term sum for Forney.
module chien_search
   import rs_pkg::*;
(
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         BM_done,
   input  logic [M-1:0] Lambda0,
   input  logic [M-1:0] Lambda1,
   input  logic [M-1:0] Lambda2,
   input  logic [M-1:0] Lambda3,
   input  logic [M-1:0] Lambda4,
   input  logic [M-1:0] Lambda5,
   input  logic [M-1:0] Lambda6,
   input  logic [M-1:0] Lambda7,
   input  logic [M-1:0] Lambda8,
   output logic         loc_valid,
   output logic [M-1:0] loc_pos,
   output logic         loc_flag,
   output logic [M-1:0] Lambda_odd,
   output logic         search_done,
   output logic [3:0]   root_cnt,
   output logic         decode_fail,
   output logic         busy
);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [M-1:0] r_lam        [0:T];
   logic [M-1:0] w_lam_in     [0:T];
   logic [M-1:0] w_lam_scaled [0:T];
   logic [M-1:0] w_lam_step   [0:T];
   logic [M-1:0] r_pos;
   logic [3:0]   r_roots;
   logic [3:0]   r_deg;
   logic         r_lam0_zero;
   logic         r_last;
   logic [M-1:0] w_sum;
   logic [M-1:0] w_odd;
   logic [3:0]   w_deg;

   assign w_lam_in[0] = Lambda0;
   assign w_lam_in[1] = Lambda1;
   assign w_lam_in[2] = Lambda2;
   assign w_lam_in[3] = Lambda3;
   assign w_lam_in[4] = Lambda4;
   assign w_lam_in[5] = Lambda5;
   assign w_lam_in[6] = Lambda6;
   assign w_lam_in[7] = Lambda7;
   assign w_lam_in[8] = Lambda8;

   // Capture scales term j by alpha^j so the first evaluation lands on alpha^1 = position n-1
   for (genvar j = 0; j <= T; j++) begin : g_term
      GF_mul u_cap (
         .i_a (w_lam_in[j]),
         .i_b (ALPHA_POW[j]),
         .o_p (w_lam_scaled[j])
      );
      gf_const_mul #(.CONST(ALPHA_POW[j])) u_step (
         .i_a (r_lam[j]),
         .o_p (w_lam_step[j])
      );
   end

   always_comb begin
      w_sum = '0;
      w_odd = '0;
      w_deg = '0;
      for (int j = 0; j <= T; j++) begin
         w_sum = w_sum ^ r_lam[j];
         if (j % 2 == 1) w_odd = w_odd ^ r_lam[j];
         if (j > 0 && w_lam_in[j] != '0) w_deg = 4'(j);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // A new BM_done always wins, including on the final search edge
   always_comb begin
      w_state_nxt = r_state;
      if (BM_done)                                     w_state_nxt = ST_SEARCH;
      else if (r_state == ST_SEARCH && r_pos == '0)    w_state_nxt = ST_IDLE;
   end

   always_comb begin
      busy = (r_state == ST_SEARCH);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int j = 0; j <= T; j++) r_lam[j] <= '0;
         r_pos       <= '0;
         r_roots     <= '0;
         r_deg       <= '0;
         r_lam0_zero <= 1'b0;
         r_last      <= 1'b0;
         loc_valid   <= 1'b0;
         loc_pos     <= '0;
         loc_flag    <= 1'b0;
         Lambda_odd  <= '0;
         search_done <= 1'b0;
         root_cnt    <= '0;
         decode_fail <= 1'b0;
      end else if (BM_done) begin
         for (int j = 0; j <= T; j++) r_lam[j] <= w_lam_scaled[j];
         r_pos       <= 8'(N - 1);
         r_roots     <= '0;
         r_deg       <= w_deg;
         r_lam0_zero <= (Lambda0 == '0);
         r_last      <= 1'b0;
         loc_valid   <= 1'b0;
         loc_flag    <= 1'b0;
         search_done <= 1'b0;
         root_cnt    <= '0;
         decode_fail <= 1'b0;
      end else if (r_state == ST_SEARCH) begin
         for (int j = 0; j <= T; j++) r_lam[j] <= w_lam_step[j];
         loc_valid  <= 1'b1;
         loc_pos    <= r_pos;
         loc_flag   <= (w_sum == '0);
         Lambda_odd <= w_odd;
         if (w_sum == '0 && r_roots != 4'hF) r_roots <= r_roots + 4'd1;
         r_pos       <= r_pos - 8'd1;
         r_last      <= (r_pos == '0);
         search_done <= 1'b0;
      end else begin
         // r_last marks the cycle after pos 0 was presented; results publish here
         loc_valid   <= 1'b0;
         loc_flag    <= 1'b0;
         search_done <= r_last;
         r_last      <= 1'b0;
         if (r_last) begin
            root_cnt    <= r_roots;
            decode_fail <= (r_roots != r_deg) || r_lam0_zero;
         end
      end
   end

endmodule

// File: tb/tb_chien_search.sv
// Self-checking bench for chien_search: directed table, random locators and disruption
// sequences, all checked against a log/antilog-table evaluation of Lambda at each position.
`timescale 1ns/1ps
module tb_chien_search;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       BM_done;
   logic [7:0] Lambda0, Lambda1, Lambda2, Lambda3, Lambda4, Lambda5, Lambda6, Lambda7, Lambda8;
   logic       loc_valid;
   logic [7:0] loc_pos;
   logic       loc_flag;
   logic [7:0] Lambda_odd;
   logic       search_done;
   logic [3:0] root_cnt;
   logic       decode_fail;
   logic       busy;

   chien_search dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .BM_done     (BM_done),
      .Lambda0     (Lambda0),
      .Lambda1     (Lambda1),
      .Lambda2     (Lambda2),
      .Lambda3     (Lambda3),
      .Lambda4     (Lambda4),
      .Lambda5     (Lambda5),
      .Lambda6     (Lambda6),
      .Lambda7     (Lambda7),
      .Lambda8     (Lambda8),
      .loc_valid   (loc_valid),
      .loc_pos     (loc_pos),
      .loc_flag    (loc_flag),
      .Lambda_odd  (Lambda_odd),
      .search_done (search_done),
      .root_cnt    (root_cnt),
      .decode_fail (decode_fail),
      .busy        (busy)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   int exp_t [0:254];
   int log_t [0:255];

   logic [0:8][7:0] lam_cur;
   int rpos [0:7];

   bit m_flag [0:254];
   int m_odd  [0:254];
   int m_rc;
   int m_df;

   typedef struct {
      logic [0:8][7:0] lam;
      int              rc;
      int              df;
      string           name;
   } vec_t;

   vec_t vecs [0:7];

   function automatic void chk(input string name, input bit ok, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   // Multiply lam_cur by (1 + alpha^p x): adds a root at codeword position p
   task automatic mul_root(input int p);
      int a;
      a = exp_t[p % 255];
      for (int j = 8; j >= 1; j--)
         lam_cur[j] = lam_cur[j] ^ 8'(gmul(a, int'(lam_cur[j-1])));
   endtask

   task automatic build_lam(input int np, input int g);
      lam_cur    = '0;
      lam_cur[0] = 8'(exp_t[g % 255]);
      for (int i = 0; i < np; i++) mul_root(rpos[i]);
   endtask

   // Evaluate Lambda(alpha^-p) term by term for every position
   task automatic compute_model();
      int deg;
      m_rc = 0;
      deg  = 0;
      for (int j = 1; j <= 8; j++) if (lam_cur[j] != 8'h00) deg = j;
      for (int p = 0; p < 255; p++) begin
         int e, s, o, tm;
         e = (255 - p) % 255;
         s = 0;
         o = 0;
         for (int j = 0; j <= 8; j++) begin
            tm = gmul(int'(lam_cur[j]), exp_t[(e * j) % 255]);
            s  = s ^ tm;
            if (j % 2 == 1) o = o ^ tm;
         end
         m_flag[p] = (s == 0);
         m_odd[p]  = o;
         if (s == 0 && m_rc < 15) m_rc++;
      end
      m_df = (m_rc != deg || lam_cur[0] == 8'h00) ? 1 : 0;
   endtask

   task automatic drive_lam(input logic [0:8][7:0] v);
      Lambda0 = v[0]; Lambda1 = v[1]; Lambda2 = v[2];
      Lambda3 = v[3]; Lambda4 = v[4]; Lambda5 = v[5];
      Lambda6 = v[6]; Lambda7 = v[7]; Lambda8 = v[8];
   endtask

   task automatic garbage_lam();
      logic [0:8][7:0] g;
      for (int j = 0; j <= 8; j++) g[j] = 8'($urandom);
      drive_lam(g);
   endtask

   task automatic launch(input bit now);
      compute_model();
      if (!now) @(negedge clk_in);
      drive_lam(lam_cur);
      BM_done = 1'b1;
      @(negedge clk_in);
      BM_done = 1'b0;
      garbage_lam();
      chk("start_gap", loc_valid == 1'b0 && busy == 1'b1 && root_cnt == 4'd0 &&
          decode_fail == 1'b0 && search_done == 1'b0,
          {loc_valid, busy, root_cnt, decode_fail, search_done}, 8'b0100_0000);
   endtask

   task automatic walk(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         int p;
         @(negedge clk_in);
         p = 254 - c;
         chk($sformatf("pos_%0d", p),
             loc_valid == 1'b1 && loc_pos == 8'(p) && loc_flag == m_flag[p] &&
             Lambda_odd == 8'(m_odd[p]) && search_done == 1'b0 && busy == (c < 254),
             {loc_valid, loc_pos, loc_flag, Lambda_odd, search_done},
             {1'b1, 8'(p), m_flag[p], 8'(m_odd[p]), 1'b0});
      end
   endtask

   task automatic finish_frame(input string name, input int rc, input int df);
      @(negedge clk_in);
      chk({name, "_done"}, loc_valid == 1'b0 && search_done == 1'b1 && busy == 1'b0 &&
          root_cnt == 4'(rc) && decode_fail == df[0],
          {loc_valid, search_done, busy, root_cnt, decode_fail},
          {1'b0, 1'b1, 1'b0, 4'(rc), df[0]});
      @(negedge clk_in);
      chk({name, "_hold"}, search_done == 1'b0 && root_cnt == 4'(rc) && decode_fail == df[0],
          {search_done, root_cnt, decode_fail}, {1'b0, 4'(rc), df[0]});
   endtask

   task automatic run_frame(input string name, input int rc, input int df);
      int erc, edf;
      launch(1'b0);
      walk(255);
      erc = (rc < 0) ? m_rc : rc;
      edf = (rc < 0) ? m_df : df;
      finish_frame(name, erc, edf);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {loc_valid, loc_pos, loc_flag, Lambda_odd, search_done, root_cnt, decode_fail, busy} == '0,
          {loc_valid, loc_pos, loc_flag, Lambda_odd, search_done, root_cnt, decode_fail, busy}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      bit found;
      v = 1;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = v;
         log_t[v] = i;
         v = v << 1;
         if (v & 256) v = v ^ 32'h11D;
      end
      log_t[0] = 0;

      // Directed table; built entries are filled from root lists
      vecs[0].lam = '0; vecs[0].lam[0] = 8'h01;                          vecs[0].rc = 0;  vecs[0].df = 0; vecs[0].name = "no_err";
      vecs[1].lam = '0; vecs[1].lam[0] = 8'h01; vecs[1].lam[1] = 8'h8E;  vecs[1].rc = 1;  vecs[1].df = 0; vecs[1].name = "err_254";
      vecs[2].lam = '0; vecs[2].lam[0] = 8'h01; vecs[2].lam[1] = 8'h01;  vecs[2].rc = 1;  vecs[2].df = 0; vecs[2].name = "err_0";
      rpos[0] = 10; rpos[1] = 200; build_lam(2, 5);
      vecs[3].lam = lam_cur;                                             vecs[3].rc = 2;  vecs[3].df = 0; vecs[3].name = "err_10_200";
      found = 1'b0;
      for (int c = 2; c < 256 && !found; c++) begin
         lam_cur = '0; lam_cur[0] = 8'h01; lam_cur[1] = 8'h01; lam_cur[2] = 8'(c);
         mul_root(20);
         compute_model();
         if (m_rc == 1) found = 1'b1;
      end
      vecs[4].lam = lam_cur;                                             vecs[4].rc = 1;  vecs[4].df = 1; vecs[4].name = "deg3_1root";
      vecs[5].lam = '0;                                                  vecs[5].rc = 15; vecs[5].df = 1; vecs[5].name = "all_zero";
      vecs[6].lam = '0; vecs[6].lam[1] = 8'h01;                          vecs[6].rc = 0;  vecs[6].df = 1; vecs[6].name = "lam0_zero";
      rpos[0] = 0; rpos[1] = 254; rpos[2] = 128; build_lam(3, 77);
      vecs[7].lam = lam_cur;                                             vecs[7].rc = 3;  vecs[7].df = 0; vecs[7].name = "err_0_128_254";

      rst_in  = 1'b1;
      BM_done = 1'b0;
      garbage_lam();
      repeat (3) @(negedge clk_in);
      chk_all_zero("reset_state");
      rst_in = 1'b0;
      @(negedge clk_in);
      chk_all_zero("idle_after_reset");

      for (int i = 0; i < 8; i++) begin
         lam_cur = vecs[i].lam;
         run_frame(vecs[i].name, vecs[i].rc, vecs[i].df);
      end

      // Random locators with a known set of distinct roots
      for (int f = 0; f < 4; f++) begin
         int nr;
         nr = $urandom_range(1, 8);
         for (int i = 0; i < nr; i++) begin
            bit dup;
            do begin
               rpos[i] = $urandom_range(0, 254);
               dup = 1'b0;
               for (int q = 0; q < i; q++) if (rpos[q] == rpos[i]) dup = 1'b1;
            end while (dup);
         end
         build_lam(nr, $urandom_range(0, 254));
         run_frame($sformatf("rand_roots_%0d", f), nr, 0);
      end

      // Arbitrary coefficients: root count and failure come from the model
      for (int f = 0; f < 3; f++) begin
         lam_cur = '0;
         for (int j = 0; j <= int'($urandom_range(1, 8)); j++) lam_cur[j] = 8'($urandom);
         run_frame($sformatf("rand_coef_%0d", f), -1, 0);
      end

      // Restart at valid cycle 100
      lam_cur = vecs[1].lam;
      launch(1'b0);
      walk(101);
      lam_cur = vecs[3].lam;
      launch(1'b1);
      walk(255);
      finish_frame("restart_mid", 2, 0);

      // Restart coincident with the final search edge: pos 0 never shown, no done pulse
      lam_cur = vecs[2].lam;
      launch(1'b0);
      walk(254);
      lam_cur = vecs[0].lam;
      launch(1'b1);
      walk(255);
      finish_frame("restart_last", 0, 0);

      // Reset mid-search
      lam_cur = vecs[7].lam;
      launch(1'b0);
      walk(50);
      rst_in = 1'b1;
      @(negedge clk_in);
      chk_all_zero("reset_mid_search");
      rst_in = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         chk_all_zero("idle_after_mid_reset");
      end
      lam_cur = vecs[3].lam;
      run_frame("after_reset", 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
